// File: rtl/io_syscall_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Brief    : Service codes and FSM encoding shared by the I/O responder and
//            the control unit's IORead/IOWrite decode.
// Revision : 1.0
// ============================================================================
package io_pkg;

    localparam logic [31:0] SVC_RD_SW_WAIT = 32'd0;
    localparam logic [31:0] SVC_RD_SW      = 32'd1;
    localparam logic [31:0] SVC_RD_SW8S    = 32'd2;
    localparam logic [31:0] SVC_RD_BTN     = 32'd3;
    localparam logic [31:0] SVC_WR_LED     = 32'd4;
    localparam logic [31:0] SVC_WR_SEG     = 32'd5;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_DONE         = 2'd3
    } io_state_t;

    function automatic logic is_read_service(input logic [31:0] svc);
        return (svc <= SVC_RD_BTN);
    endfunction

    function automatic logic is_write_service(input logic [31:0] svc);
        return (svc == SVC_WR_LED) || (svc == SVC_WR_SEG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_syscall_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : io_syscall_responder_if
// Brief    : CPU-side request/response bundle of the I/O syscall responder.
// Revision : 1.0
// ============================================================================
interface io_syscall_responder_if;

    logic        io_read;
    logic        io_write;
    logic [31:0] service;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        io_stall;
    logic        io_done;

    modport master (
        output io_read, io_write, service, wdata,
        input  rdata, io_stall, io_done
    );

    modport slave (
        input  io_read, io_write, service, wdata,
        output rdata, io_stall, io_done
    );

endinterface
`default_nettype wire

// File: rtl/io_syscall_responder_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-flop synchronizer plus stable-level counter for one button.
// Revision : 1.0
// ============================================================================
module btn_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_btn,
    output logic      o_level
);

    logic        r_meta;
    logic        r_sync;
    logic        r_sync_prev;
    logic [19:0] r_cnt;
    logic        r_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta      <= 1'b0;
            r_sync      <= 1'b0;
            r_sync_prev <= 1'b0;
            r_cnt       <= 20'd0;
            r_level     <= 1'b0;
        end else begin
            r_meta      <= i_btn;
            r_sync      <= r_meta;
            r_sync_prev <= r_sync;
            // Any change restarts the stability window; once full, the
            // counter parks and the output simply tracks the stable input.
            if (r_sync != r_sync_prev) begin
                r_cnt <= 20'd0;
            end else if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                r_level <= r_sync;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/io_syscall_responder.sv
`default_nettype none
// ============================================================================
// Module   : io_syscall_responder
// Brief    : Serves CPU I/O syscalls against switches, confirm button, LEDs
//            and the 7-segment value register; stalls until complete.
// Revision : 1.0
// ============================================================================
module io_syscall_responder
    import io_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter int          SW_WIDTH        = 16,
    parameter int          LED_WIDTH       = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    io_syscall_responder_if.slave     cpu,
    input  wire logic [SW_WIDTH-1:0]  sw,
    input  wire logic                 btn_confirm,
    output logic      [LED_WIDTH-1:0] led,
    output logic      [31:0]          seg_value
);

    io_state_t            r_state;
    logic [SW_WIDTH-1:0]  r_sw_meta;
    logic [SW_WIDTH-1:0]  r_sw_sync;
    logic                 r_btn_prev;
    logic [31:0]          r_capture;
    logic [31:0]          r_rdata;
    logic                 r_io_done;
    logic [LED_WIDTH-1:0] r_led;
    logic [31:0]          r_seg;

    logic                 w_btn;
    logic                 w_req;
    logic                 w_btn_rise;
    logic                 w_btn_fall;
    logic [31:0]          w_sw_ext;
    logic [31:0]          w_sw8_sext;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_confirm (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_confirm),
        .o_level (w_btn)
    );

    assign w_req      = cpu.io_read | cpu.io_write;
    assign w_btn_rise = w_btn & ~r_btn_prev;
    assign w_btn_fall = ~w_btn & r_btn_prev;
    assign w_sw_ext   = 32'(r_sw_sync);
    assign w_sw8_sext = {{24{r_sw_sync[7]}}, r_sw_sync[7:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_prev <= 1'b0;
            r_capture  <= 32'd0;
            r_rdata    <= 32'd0;
            r_io_done  <= 1'b0;
            r_led      <= '0;
            r_seg      <= 32'd0;
        end else begin
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
            r_btn_prev <= w_btn;
            r_io_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state   <= ST_DONE;
                        r_io_done <= 1'b1;
                        if (cpu.io_read && cpu.io_write) begin
                            r_rdata <= 32'd0;
                        end else begin
                            case (cpu.service)
                                SVC_RD_SW_WAIT: begin
                                    r_state   <= ST_WAIT_PRESS;
                                    r_io_done <= 1'b0;
                                end
                                SVC_RD_SW:   r_rdata <= w_sw_ext;
                                SVC_RD_SW8S: r_rdata <= w_sw8_sext;
                                SVC_RD_BTN:  r_rdata <= {31'd0, w_btn};
                                SVC_WR_LED:  r_led   <= cpu.wdata[LED_WIDTH-1:0];
                                SVC_WR_SEG:  r_seg   <= cpu.wdata;
                                default:     r_rdata <= 32'd0;
                            endcase
                        end
                    end
                end
                ST_WAIT_PRESS: begin
                    // Switches are captured on the press but only committed to
                    // rdata on release, so an aborted wait leaves rdata intact.
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else if (w_btn_rise) begin
                        r_capture <= w_sw_ext;
                        r_state   <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else if (w_btn_fall) begin
                        r_rdata   <= r_capture;
                        r_io_done <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall must cover the accept cycle, so it is decoded from live request.
    assign cpu.io_stall = rst_n & w_req & (r_state != ST_DONE);
    assign cpu.io_done  = r_io_done;
    assign cpu.rdata    = r_rdata;
    assign led          = r_led;
    assign seg_value    = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_io_syscall_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_syscall_responder
// Brief    : Directed self-checking bench for io_syscall_responder.
// Revision : 1.0
// ============================================================================
module tb_io_syscall_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw;
    logic        btn_confirm;
    logic [15:0] led;
    logic [31:0] seg_value;

    int checks   = 0;
    int failures = 0;

    io_syscall_responder_if bus ();

    io_syscall_responder #(
        .DEBOUNCE_CYCLES (20'd4),
        .SW_WIDTH        (16),
        .LED_WIDTH       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu         (bus),
        .sw          (sw),
        .btn_confirm (btn_confirm),
        .led         (led),
        .seg_value   (seg_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Two-cycle service: stall in the accept cycle, done pulse in the next.
    task automatic simple_req(input logic rd, input logic wr, input logic [31:0] svc, input logic [31:0] wd);
        bus.io_read  = rd;
        bus.io_write = wr;
        bus.service  = svc;
        bus.wdata    = wd;
        #1;
        check("accept_stall", {31'd0, bus.io_stall}, 32'd1);
        check("accept_no_done", {31'd0, bus.io_done}, 32'd0);
        tick();
        check("done_pulse", {31'd0, bus.io_done}, 32'd1);
        check("done_no_stall", {31'd0, bus.io_stall}, 32'd0);
        bus.io_read  = 1'b0;
        bus.io_write = 1'b0;
        tick();
        check("done_cleared", {31'd0, bus.io_done}, 32'd0);
    endtask

    // Runs n cycles, returns io_done pulses seen and cycles without stall.
    task automatic run_count(input int n, output int dones, output int no_stall);
        dones    = 0;
        no_stall = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.io_done)   dones++;
            if (!bus.io_stall) no_stall++;
        end
    endtask

    task automatic wait_done(input int limit, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (bus.io_done) seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d;
        int   ns;
        int   d2;
        int   ns2;
        logic seen;

        rst_n        = 1'b0;
        sw           = 16'h0000;
        btn_confirm  = 1'b0;
        bus.io_read  = 1'b0;
        bus.io_write = 1'b0;
        bus.service  = 32'd0;
        bus.wdata    = 32'd0;
        repeat (3) tick();
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_stall", {31'd0, bus.io_stall}, 32'd0);
        check("rst_done", {31'd0, bus.io_done}, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_seg", seg_value, 32'd0);
        rst_n = 1'b1;
        repeat (6) tick();

        simple_req(1'b0, 1'b1, 32'd4, 32'h0000_A5A5);
        check("led_write", {16'd0, led}, 32'h0000_A5A5);
        check("seg_untouched", seg_value, 32'd0);

        sw = 16'h0080;
        repeat (3) tick();
        simple_req(1'b1, 1'b0, 32'd2, 32'd0);
        check("sw8_sext_neg", bus.rdata, 32'hFFFF_FF80);
        simple_req(1'b1, 1'b0, 32'd1, 32'd0);
        check("sw_zext", bus.rdata, 32'h0000_0080);
        simple_req(1'b1, 1'b0, 32'd3, 32'd0);
        check("btn_low", bus.rdata, 32'd0);

        sw = 16'h1234;
        repeat (3) tick();
        simple_req(1'b1, 1'b0, 32'd2, 32'd0);
        check("sw8_sext_pos", bus.rdata, 32'h0000_0034);

        // Bouncy press then hold, then release.
        bus.service = 32'd0;
        bus.io_read = 1'b1;
        #1;
        check("svc0_accept_stall", {31'd0, bus.io_stall}, 32'd1);
        btn_confirm = 1'b1; run_count(1, d, ns);
        btn_confirm = 1'b0; run_count(1, d2, ns2); d += d2; ns += ns2;
        btn_confirm = 1'b1; run_count(11, d2, ns2); d += d2; ns += ns2;
        check("svc0_no_done_pressed", d, 0);
        check("svc0_stall_pressed", ns, 0);
        check("svc0_rdata_held", bus.rdata, 32'h0000_0034);
        btn_confirm = 1'b0;
        wait_done(30, seen);
        check("svc0_done_after_release", {31'd0, seen}, 32'd1);
        check("svc0_rdata", bus.rdata, 32'h0000_1234);
        bus.io_read = 1'b0;
        run_count(10, d, ns);
        check("svc0_single_done", d, 0);

        // Button already held when the request arrives.
        btn_confirm = 1'b1;
        repeat (12) tick();
        simple_req(1'b1, 1'b0, 32'd3, 32'd0);
        check("btn_high", bus.rdata, 32'd1);
        sw = 16'h00C3;
        repeat (3) tick();
        bus.service = 32'd0;
        bus.io_read = 1'b1;
        run_count(15, d, ns);
        btn_confirm = 1'b0;
        run_count(15, d2, ns2);
        check("held_no_done", d + d2, 0);
        check("held_stall", ns + ns2, 0);
        btn_confirm = 1'b1;
        run_count(15, d, ns);
        check("repress_no_done", d, 0);
        btn_confirm = 1'b0;
        wait_done(30, seen);
        check("repress_done", {31'd0, seen}, 32'd1);
        check("repress_rdata", bus.rdata, 32'h0000_00C3);
        bus.io_read = 1'b0;
        tick();

        // Request withdrawn mid-wait.
        bus.service = 32'd0;
        bus.io_read = 1'b1;
        repeat (5) tick();
        bus.io_read = 1'b0;
        #1;
        check("abort_stall", {31'd0, bus.io_stall}, 32'd0);
        run_count(10, d, ns);
        check("abort_no_done", d, 0);
        check("abort_rdata", bus.rdata, 32'h0000_00C3);
        sw = 16'h8001;
        repeat (3) tick();
        simple_req(1'b1, 1'b0, 32'd1, 32'd0);
        check("after_abort_rd", bus.rdata, 32'h0000_8001);

        simple_req(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        check("seg_write", seg_value, 32'hDEAD_BEEF);
        check("led_kept", {16'd0, led}, 32'h0000_A5A5);
        simple_req(1'b1, 1'b0, 32'd7, 32'h0000_1111);
        check("bad_svc_rdata", bus.rdata, 32'd0);
        check("bad_svc_led", {16'd0, led}, 32'h0000_A5A5);
        check("bad_svc_seg", seg_value, 32'hDEAD_BEEF);
        simple_req(1'b1, 1'b0, 32'd1, 32'd0);
        simple_req(1'b1, 1'b1, 32'd4, 32'h0000_1111);
        check("both_rdata", bus.rdata, 32'd0);
        check("both_led", {16'd0, led}, 32'h0000_A5A5);

        // Reset while waiting for a press.
        bus.service = 32'd0;
        bus.io_read = 1'b1;
        repeat (3) tick();
        rst_n       = 1'b0;
        bus.io_read = 1'b0;
        tick();
        check("rst2_rdata", bus.rdata, 32'd0);
        check("rst2_stall", {31'd0, bus.io_stall}, 32'd0);
        check("rst2_done", {31'd0, bus.io_done}, 32'd0);
        check("rst2_led", {16'd0, led}, 32'd0);
        check("rst2_seg", seg_value, 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        simple_req(1'b1, 1'b0, 32'd1, 32'd0);
        check("post_rst_rd", bus.rdata, 32'h0000_8001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
